guess_entry: RTL

- Player-input front end for the Mastermind game. Turns three raw DE10 push-buttons into a four-digit guess, each digit a colour code 1..6.
- Drives the per-position digit buses d0..d3 that feed the seven-segment display driver.
- Hands a completed guess to the game/scoring logic over a valid/ready handshake.

---
 rtl/mastermind_pkg.sv | 17 +
 rtl/key_debounce.sv | 45 ++++
 rtl/guess_entry.sv | 89 ++++++++
 3 files changed

// File: rtl/mastermind_pkg.sv
// Shared Mastermind constants and types used by guess entry, scoring and display.
package mastermind_pkg;
  localparam int DIGIT_W   = 3;
  localparam int DIGIT_MIN = 1;
  localparam int DIGIT_MAX = 6;
  localparam int NUM_POS   = 4;
  localparam int SEL_W     = $clog2(NUM_POS);
  localparam int GUESS_W   = NUM_POS * DIGIT_W;

  typedef enum logic {EDIT, SUBMIT} state_t;

  // Next colour with 6 -> 1 wrap; any out-of-range code recovers to 1.
  function automatic logic [DIGIT_W-1:0] digit_inc(input logic [DIGIT_W-1:0] d);
    if (d >= DIGIT_W'(DIGIT_MIN) && d < DIGIT_W'(DIGIT_MAX)) return d + 1'b1;
    return DIGIT_W'(DIGIT_MIN);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// Synchronises and debounces one active-low push-button; emits a 1-cycle press pulse.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2, blocked, flip;
  logic [1:0]       fill;
  logic [CNT_W-1:0] cnt;

  assign flip  = (s2 != level) && (cnt == LAST);
  // A key held through reset stays blocked until a real released sample is seen.
  assign press = flip && level && !blocked;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      level   <= 1'b1;
      cnt     <= '0;
      fill    <= '0;
      blocked <= 1'b1;
    end else begin
      s1   <= key_n;
      s2   <= s1;
      fill <= {fill[0], 1'b1};
      if (fill[1] && s2 && level) blocked <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (flip) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/guess_entry.sv
// Button-driven four-digit guess editor with a valid/ready hand-off to the game logic.
module guess_entry
  import mastermind_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_inc_n,
  input  logic               key_next_n,
  input  logic               key_submit_n,
  input  logic               guess_ready,
  output logic [DIGIT_W-1:0] d0,
  output logic [DIGIT_W-1:0] d1,
  output logic [DIGIT_W-1:0] d2,
  output logic [DIGIT_W-1:0] d3,
  output logic [SEL_W-1:0]   sel,
  output logic [GUESS_W-1:0] guess,
  output logic               guess_valid
);
  logic [2:0] raw_n, lvl, pulse;
  assign raw_n = {key_submit_n, key_next_n, key_inc_n};

  for (genvar k = 0; k < 3; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk   (clk),
      .reset (reset),
      .key_n (raw_n[k]),
      .level (lvl[k]),
      .press (pulse[k])
    );
  end

  state_t                            state, state_nx;
  logic [NUM_POS-1:0][DIGIT_W-1:0]   dig, dig_nx;
  logic [SEL_W-1:0]                  sel_nx;
  logic [GUESS_W-1:0]                guess_nx;
  logic                              valid_nx;

  always_comb begin
    state_nx = state;
    dig_nx   = dig;
    sel_nx   = sel;
    guess_nx = guess;
    valid_nx = guess_valid;
    case (state)
      EDIT: begin
        if (pulse[2]) begin
          guess_nx = dig;
          valid_nx = 1'b1;
          state_nx = SUBMIT;
        end else begin
          if (pulse[0]) dig_nx[sel] = digit_inc(dig[sel]);
          if (pulse[1]) sel_nx = sel + 1'b1;
        end
      end
      SUBMIT: begin
        // Digits and selection are kept so the player edits from the last guess.
        if (guess_ready) begin
          valid_nx = 1'b0;
          state_nx = EDIT;
        end
      end
      default: state_nx = EDIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EDIT;
      dig         <= {NUM_POS{DIGIT_W'(DIGIT_MIN)}};
      sel         <= '0;
      guess       <= '0;
      guess_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      dig         <= dig_nx;
      sel         <= sel_nx;
      guess       <= guess_nx;
      guess_valid <= valid_nx;
    end
  end

  assign d0 = dig[0];
  assign d1 = dig[1];
  assign d2 = dig[2];
  assign d3 = dig[3];
endmodule
